riscv_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the combinational decoder. It owns the PC, issues in-order word requests to instruction memory over a valid/ready request channel, and buffers returned instruction words in a small FIFO. It presents {instruction, pc} pairs to the decode stage with a valid/ready handshake. Redirects from branch/jump resolution flush the FIFO and discard responses still in flight.

---
 rtl/riscv_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: owns the PC, issues in-order word fetches to instruction
// memory, buffers responses in a small FIFO and hands {instr, pc} to decode.
// Redirects flush the FIFO and mark in-flight responses stale.
// Optional build macro: RISCV_FETCH_MISALIGN_CHECK_EN (misaligned-target trap).
module riscv_fetch_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_misaligned,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {RUN, TRAP, HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  stale;
    logic [CNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [31:0]       instr_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];

    logic              req_fire;
    logic              rsp_live;
    logic              rsp_drop;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              redirect_drop;
    logic [SUM_W-1:0]  credit_used;
    logic [ADDR_W-1:0] redirect_tgt;

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    logic [ADDR_W-1:0] trap_pc;
    logic              trap_show;
    logic              trap_pop;
    logic              redirect_misaligned;

    assign redirect_misaligned = redirect_pc[1:0] != 2'b00;
    assign trap_show           = (state == TRAP) && (stale == '0);
    assign trap_pop            = trap_show && out_ready && !redirect_valid;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    // Fetch addresses stay word-aligned; a misaligned target is carried separately for the trap entry.
    assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Every request and every live or stale response holds a FIFO slot, so no response can overflow.
    assign credit_used    = SUM_W'(outstanding) + SUM_W'(stale) + SUM_W'(fifo_count);
    assign imem_req_valid = !rst && (state == RUN) && !redirect_valid
                            && (credit_used < SUM_W'(FIFO_DEPTH));
    assign imem_req_addr  = req_pc;

    assign req_fire      = imem_req_valid && imem_req_ready;
    assign rsp_drop      = imem_rsp_valid && (stale != '0);
    assign rsp_live      = imem_rsp_valid && (stale == '0);
    assign fifo_push     = rsp_live && !redirect_valid;
    assign fifo_empty    = fifo_count == '0;
    assign fifo_pop      = !fifo_empty && out_ready && !redirect_valid;
    assign redirect_drop = imem_rsp_valid && ((stale != '0) || (outstanding != '0));

    // Decode-facing view: FIFO head, or the trap marker once stale responses have drained.
    always_comb begin
        out_valid      = !fifo_empty;
        out_instr      = '0;
        out_pc         = '0;
        out_misaligned = 1'b0;
        if (!fifo_empty) begin
            out_instr = instr_mem[rd_ptr];
            out_pc    = pc_mem[rd_ptr];
        end
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
        if (trap_show) begin
            out_valid      = 1'b1;
            out_instr      = NOP;
            out_pc         = trap_pc;
            out_misaligned = 1'b1;
        end
`endif
    end

    // FIFO storage; contents are only observed through the count-qualified head.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            instr_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]    <= rsp_pc;
        end
    end

    // PCs, credit counters, FIFO pointers and fetch state; redirect overrides all other updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
            trap_pc     <= '0;
`endif
        end else if (redirect_valid) begin
            req_pc      <= redirect_tgt;
            rsp_pc      <= redirect_tgt;
            stale       <= stale + outstanding - CNT_W'(redirect_drop);
            outstanding <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
            trap_pc     <= redirect_pc;
            state       <= redirect_misaligned ? TRAP : RUN;
`endif
        end else begin
            if (req_fire) begin
                req_pc <= req_pc + ADDR_W'(4);
            end
            if (fifo_push) begin
                rsp_pc <= rsp_pc + ADDR_W'(4);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (rsp_drop) begin
                stale <= stale - CNT_W'(1);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_live);
            fifo_count  <= fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
            if (trap_pop) begin
                state <= HALT;
            end
`endif
        end
    end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Testbench for riscv_fetch_unit: cycle-exact vector table for startup,
// redirect and backpressure, then scoreboard-checked multi-cycle sequences
// driven through a behavioural in-order instruction memory.
module tb_riscv_fetch_unit;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_misaligned;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    riscv_fetch_unit #(
        .ADDR_W    (32),
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_misaligned(out_misaligned),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    typedef struct {
        logic        ordy;
        logic        rv;
        logic [31:0] rpc;
        logic        exp_rv;
        logic [31:0] exp_ra;
        logic        exp_ov;
        logic [31:0] exp_opc;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   lat    = 1;
    int   epoch  = 0;
    int   buffered = 0;
    bit   sb_en  = 1'b1;
    logic [31:0] exp_pc  = 32'h0;
    logic [31:0] exp_req = 32'h0;
    req_t q[$];
    vec_t tbl[20];

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_out_valid;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_instr;
    logic        s_mis;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] tgt_of(input logic [31:0] rpc);
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
        return rpc;
`else
        return {rpc[31:2], 2'b00};
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs and memory response, sample at negedge, update model.
    task automatic step(input logic ordy, input logic rrdy, input logic rv, input logic [31:0] rpc);
        bit live;
        out_ready      = ordy;
        imem_req_ready = rrdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (q.size() > 0 && q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;
        s_mis       = out_misaligned;
        if (rv) chk("no_req_on_redirect", {31'h0, s_req_valid}, 32'h0);
        if (imem_rsp_valid) begin
            live = (q[0].epoch == epoch) && !rv;
            void'(q.pop_front());
            if (live) buffered++;
        end
        if (s_req_valid && rrdy) begin
            chk("req_addr", s_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            q.push_back('{addr: s_req_addr, due: cyc + lat, epoch: epoch});
        end
        if (s_out_valid && ordy && !rv && !s_mis) begin
            buffered--;
            if (sb_en) begin
                chk("sb_out_pc", s_out_pc, exp_pc);
                chk("sb_out_instr", s_out_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (rv) begin
            epoch++;
            buffered = 0;
            exp_pc   = tgt_of(rpc);
            exp_req  = {rpc[31:2], 2'b00};
        end
        chk("credit_bound", {31'h0, (q.size() + buffered) <= int'(DEPTH)}, 32'h1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Run until the next visible output (popped), compare its pc; missing output within budget fails.
    task automatic expect_next_out(input string name, input logic [31:0] pc, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_out_valid) begin
                seen = 1'b1;
                chk(name, s_out_pc, pc);
                chk({name, "_instr"}, s_out_instr, mem_word(pc));
            end
        end
        chk({name, "_seen"}, {31'h0, seen}, 32'h1);
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Startup with lat 1, redirect to 0x100, then a decoder stall.
        tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h000};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b0, 32'h000};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h008};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h00C};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h014, 1'b0, 32'h000};
        tbl[8]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h000, 1'b1, 32'h010};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000};
        tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h100};
        tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b0, 32'h000};
        tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h108};
        tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h108};
        tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h108};
        tbl[17] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h108};
        tbl[18] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h110, 1'b1, 32'h10C};
        tbl[19] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h114, 1'b0, 32'h000};

        // Outputs held while reset is asserted.
        @(negedge clk);
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_misaligned", {31'h0, out_misaligned}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].ordy, 1'b1, tbl[i].rv, tbl[i].rpc);
            chk($sformatf("vec%0d_req_valid", i), {31'h0, s_req_valid}, {31'h0, tbl[i].exp_rv});
            if (tbl[i].exp_rv) chk($sformatf("vec%0d_req_addr", i), s_req_addr, tbl[i].exp_ra);
            chk($sformatf("vec%0d_out_valid", i), {31'h0, s_out_valid}, {31'h0, tbl[i].exp_ov});
            if (tbl[i].exp_ov) begin
                chk($sformatf("vec%0d_out_pc", i), s_out_pc, tbl[i].exp_opc);
                chk($sformatf("vec%0d_out_instr", i), s_out_instr, mem_word(tbl[i].exp_opc));
            end
            chk($sformatf("vec%0d_misaligned", i), {31'h0, s_mis}, 32'h0);
        end

        // Long decoder stall then release: nothing lost, order preserved.
        lat = 1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Memory ready toggling 1010 with 3-cycle latency.
        lat = 3;
        for (int i = 0; i < 40; i++) step(1'b1, (i % 2) == 0, 1'b0, 32'h0);

        // Two requests in flight, redirect to 0x100: both responses must be dropped.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (q.size() == 2) found = 1'b1;
            else step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        chk("two_in_flight", {31'h0, found}, 32'h1);
        step(1'b1, 1'b1, 1'b1, 32'h100);
        expect_next_out("redir_first_pc", 32'h100, 30);
        expect_next_out("redir_second_pc", 32'h104, 30);

        // Redirect coinciding with a response and a pop, then redirect to 0x200.
        lat = 2;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (q.size() > 0 && q[0].due <= cyc && out_valid) begin
                step(1'b1, 1'b1, 1'b1, 32'h180);
                step(1'b1, 1'b1, 1'b1, 32'h200);
                found = 1'b1;
            end else begin
                step(1'b1, 1'b1, 1'b0, 32'h0);
            end
        end
        chk("rsp_pop_redirect_hit", {31'h0, found}, 32'h1);
        expect_next_out("b2b_first_pc", 32'h200, 30);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Reset mid-operation clears outputs at once and restarts at RESET_PC.
        rst = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("midrst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        epoch++;
        buffered = 0;
        exp_pc   = 32'h0;
        exp_req  = 32'h0;
        cyc      = 0;
        lat      = 1;
        expect_next_out("post_reset_pc", 32'h0, 20);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
        // Misaligned target traps: no fetch, one NOP marker entry, then halt until redirect.
        lat = 2;
        sb_en = 1'b0;
        step(1'b1, 1'b1, 1'b1, 32'h102);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("trap_no_req", {31'h0, s_req_valid}, 32'h0);
            if (s_out_valid) found = 1'b1;
        end
        chk("trap_seen", {31'h0, found}, 32'h1);
        chk("trap_misaligned", {31'h0, s_mis}, 32'h1);
        chk("trap_instr", s_out_instr, 32'h0000_0013);
        chk("trap_pc", s_out_pc, 32'h102);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("trap_pop_valid", {31'h0, s_out_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            chk("halt_out_valid", {31'h0, s_out_valid}, 32'h0);
            chk("halt_no_req", {31'h0, s_req_valid}, 32'h0);
        end
        sb_en = 1'b1;
        step(1'b1, 1'b1, 1'b1, 32'h300);
        expect_next_out("resume_pc", 32'h300, 20);
        expect_next_out("resume_pc2", 32'h304, 20);
`else
        // Without the trap, a misaligned target is fetched from its word-aligned address.
        lat = 2;
        step(1'b1, 1'b1, 1'b1, 32'h102);
        expect_next_out("align_forced_pc", 32'h100, 20);
        chk("align_forced_mis", {31'h0, s_mis}, 32'h0);
        expect_next_out("align_forced_pc2", 32'h104, 20);
`endif

        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
